// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   // Active-low seven-segment patterns, bit order g..a.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

endpackage

// File: rtl/bin_to_bcd_seq_seg7.sv
// One BCD digit to an active-low seven-segment pattern (g..a); codes 10..15 are blank.
module bcd_seg7_enc
   import bin_to_bcd_seq_pkg::*;
(
   input  bcd_digit_t  bcd_in,
   output logic [6:0]  seg_out
);

   // Pure table decode of one digit
   always_comb begin
      seg_out = SEG_BLANK;
      case (bcd_in)
         4'd0:    seg_out = SEG_ZERO;
         4'd1:    seg_out = 7'b1111001;
         4'd2:    seg_out = 7'b0100100;
         4'd3:    seg_out = 7'b0110000;
         4'd4:    seg_out = 7'b0011001;
         4'd5:    seg_out = 7'b0010010;
         4'd6:    seg_out = 7'b0000010;
         4'd7:    seg_out = 7'b1111000;
         4'd8:    seg_out = 7'b0000000;
         4'd9:    seg_out = 7'b0010000;
         default: seg_out = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one bit per SHIFT cycle, result
// registered on leaving DONE, plus a per-digit seven-segment decode.
//
// state | meaning
// IDLE  | waiting for start; operand latched on the accepting edge
// SHIFT | one add-3 / shift-left step per cycle, WIDTH cycles total
// DONE  | result copied to bcd_out, done pulses, back to IDLE
module bin_to_bcd_seq
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd_out,
   output logic [DIGITS*7-1:0]   seg
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]       sh_q, sh_d;
   logic [DIGITS*4-1:0]    work_q, work_d;
   logic [DIGITS*4-1:0]    bcd_q, bcd_d;
   logic                   done_q, done_d;
   logic [DIGITS*4-1:0]    adj;

   // Next-state, datapath step and result capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      work_d  = work_q;
      bcd_d   = bcd_q;
      done_d  = 1'b0;

      // Correct every digit that would overflow past 9 once doubled.
      adj = work_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_q[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = work_q[i*4 +: 4] + 4'd3;
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = bin_in;
               work_d  = '0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            work_d = {adj[DIGITS*4-2:0], sh_q[WIDTH-1]};
            sh_d   = {sh_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_d   = work_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         work_q  <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         work_q  <= work_d;
         bcd_q   <= bcd_d;
         done_q  <= done_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign bcd_out = bcd_q;

   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      bcd_seg7_enc u_enc (
         .bcd_in  (bcd_q[g*4 +: 4]),
         .seg_out (seg[g*7 +: 7])
      );
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (WIDTH=8, DIGITS=3).
module tb_bin_to_bcd_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  bin_in;
   logic        busy;
   logic        done;
   logic [11:0] bcd_out;
   logic [20:0] seg;

   int n_checks = 0;
   int n_errors = 0;

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out),
      .seg     (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] bcd_ref(input int v);
      return 12'((v / 100) % 10) << 8 | 12'((v / 10) % 10) << 4 | 12'(v % 10);
   endfunction

   function automatic logic [6:0] seg_ref(input int d);
      logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
      if (d > 9) return 7'b1111111;
      return tbl[d];
   endfunction

   function automatic logic [20:0] seg_all_ref(input int v);
      return {seg_ref((v / 100) % 10), seg_ref((v / 10) % 10), seg_ref(v % 10)};
   endfunction

   // Called at a negedge; returns at the negedge where done is seen (or after the budget).
   task automatic do_convert(input logic [7:0] v, input bit noisy,
                             output int lat, output int busy_cyc);
      start  = 1'b1;
      bin_in = v;
      @(posedge clk);
      lat = 0;
      busy_cyc = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (busy) busy_cyc++;
         if (done) begin
            lat = c;
            break;
         end
         start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noisy) bin_in = 8'($urandom);
      end
      start = 1'b0;
   endtask

   initial begin
      int lat, bcyc, ndone, first_done;
      int times [4];

      rst_n  = 1'b0;
      start  = 1'b0;
      bin_in = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bcd", bcd_out, 0);
      check("rst_seg", seg, {3{7'b1000000}});

      // Zero operand, start on the very first edge after reset release
      rst_n = 1'b1;
      do_convert(8'd0, 1'b0, lat, bcyc);
      check("zero_lat", lat, 10);
      check("zero_bcd", bcd_out, 12'h000);
      check("zero_seg", seg, {3{7'b1000000}});

      // Full-scale operand
      do_convert(8'd255, 1'b0, lat, bcyc);
      check("ff_lat", lat, 10);
      check("ff_busy_cycles", bcyc, 9);
      check("ff_bcd", bcd_out, 12'h255);
      check("ff_seg", seg, seg_all_ref(255));
      @(negedge clk);
      check("ff_done_width", done, 0);
      check("ff_busy_idle", busy, 0);
      check("ff_hold", bcd_out, 12'h255);

      // Operand change and a second start during conversion are ignored
      start  = 1'b1;
      bin_in = 8'd99;
      @(posedge clk);
      ndone = 0;
      first_done = 0;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (first_done == 0) first_done = c;
         end
         start = (c == 3);
         if (c == 3) bin_in = 8'd7;
      end
      start = 1'b0;
      check("mid_ndone", ndone, 1);
      check("mid_lat", first_done, 10);
      check("mid_bcd", bcd_out, 12'h099);

      // Reset during SHIFT aborts cleanly
      do_convert(8'd200, 1'b0, lat, bcyc);
      check("pre_rst_bcd", bcd_out, 12'h200);
      start  = 1'b1;
      bin_in = 8'd42;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_bcd", bcd_out, 0);
      check("abort_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", ndone, 0);
      check("abort_bcd_hold", bcd_out, 0);
      do_convert(8'd128, 1'b0, lat, bcyc);
      check("post_rst_lat", lat, 10);
      check("post_rst_bcd", bcd_out, 12'h128);

      // Back-to-back with start held high
      start  = 1'b1;
      bin_in = 8'd37;
      @(posedge clk);
      ndone = 0;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (done) begin
            if (ndone < 4) times[ndone] = c;
            ndone++;
         end
         if (c == 10) check("b2b_first_bcd", bcd_out, 12'h037);
         if (c == 20) check("b2b_second_bcd", bcd_out, 12'h214);
         if (c == 1) bin_in = 8'd214;
      end
      start = 1'b0;
      check("b2b_ndone", ndone, 2);
      if (ndone >= 2) begin
         check("b2b_first_at", times[0], 10);
         check("b2b_spacing", times[1] - times[0], 10);
      end
      repeat (12) @(negedge clk);

      // Exhaustive sweep with random noise on start/bin_in while busy
      for (int v = 0; v < 256; v++) begin
         do_convert(8'(v), 1'b1, lat, bcyc);
         check($sformatf("sweep_lat_%0d", v), lat, 10);
         check($sformatf("sweep_bcd_%0d", v), bcd_out, bcd_ref(v));
         check($sformatf("sweep_seg_%0d", v), seg, seg_all_ref(v));
      end

      // Random operands with random idle gaps
      for (int n = 0; n < 40; n++) begin
         int v;
         v = int'($urandom_range(0, 255));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_convert(8'(v), 1'b1, lat, bcyc);
         check($sformatf("rand_busy_%0d", v), bcyc, 9);
         check($sformatf("rand_bcd_%0d", v), bcd_out, bcd_ref(v));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, binary input width; legal range 4..10.
REQ-002 SHALL have parameter DIGITS, default 3, number of BCD output digits; DIGITS*4 SHALL be wide enough that 2^WIDTH-1 fits in DIGITS decimal digits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: conversion request, sampled on the clock edge.
REQ-006 SHALL have port bin_in, input, WIDTH bits: unsigned binary operand, sampled only when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when a new result is loaded.
REQ-009 SHALL have port bcd_out, output, DIGITS*4 bits: registered result; digit 0 occupies bits [3:0].
REQ-010 SHALL have port seg, output, DIGITS*7 bits: active-low seven-segment patterns for each bcd_out digit, digit 0 in [6:0].

Function
REQ-011 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1, SHALL latch bin_in into the shift register, clear the working BCD register, load the bit counter with WIDTH, and go to SHIFT.
REQ-013 In each SHIFT cycle, SHALL first add 3 to every working digit >= 5, then shift {working BCD, shift register} left by one, and decrement the counter.
REQ-014 SHALL leave SHIFT for DONE on the cycle in which the counter reaches 0, after exactly WIDTH shift cycles.
REQ-015 In DONE, SHALL copy the working BCD register to bcd_out, assert done for that one cycle, and return to IDLE.
REQ-016 Latency: with start accepted at edge k, done SHALL be high for the cycle after edge k+WIDTH+1, and bcd_out SHALL be valid from that same edge.
REQ-017 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-018 start SHALL be ignored while busy; bin_in changes during conversion SHALL NOT affect the result.
REQ-019 bcd_out SHALL hold its last value until the next DONE.
REQ-020 seg SHALL be a combinational decode of bcd_out using active-low patterns with bit order g..a (0 = 7'b1000000); digit codes 10..15 SHALL display blank (7'b1111111).
REQ-021 bin_in=0 SHALL produce bcd_out=0, and the shift add-3 correction SHALL never produce a digit above 9.

Reset
REQ-022 While rst_n=0, SHALL hold state=IDLE, counter=0, shift and working registers=0, bcd_out=0, busy=0 and done=0; seg SHALL therefore show "0" on every digit.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion without asserting done, and bcd_out SHALL read 0.
REQ-024 After rst_n deasserts, start SHALL be accepted on the first clock edge.

Structure
REQ-025 A shared package SHALL hold the FSM state enum (IDLE/SHIFT/DONE), the 4-bit BCD digit typedef, and the blank and zero segment constants.
REQ-026 A single sub-module, bcd_seg7_enc (4-bit BCD in, 7-bit active-low out), SHALL be instantiated once per digit.
REQ-027 The add-3 correction SHALL be a loop over DIGITS inside bin_to_bcd_seq, with no further sub-modules.

Verification
REQ-028 Bench SHALL cover: start with bin_in=8'd0 -> done at cycle 10, bcd_out=12'h000, seg={3{7'b1000000}}.
REQ-029 Bench SHALL cover: bin_in=8'd255 -> bcd_out=12'h255, busy high for 9 cycles, done high for 1 cycle.
REQ-030 Bench SHALL cover: bin_in=8'd99, with bin_in changed to 8'd7 and start pulsed again mid-conversion -> bcd_out=12'h099 and exactly one done pulse.
REQ-031 Bench SHALL cover: rst_n low at SHIFT cycle 4 -> no done pulse, bcd_out=0, busy=0, and a following conversion of 8'd128 returns 12'h128.
REQ-032 Bench SHALL cover: back-to-back requests with start held high -> second conversion starts in the cycle after DONE, and done pulses are 10 cycles apart.
REQ-033 Bench SHALL cover: an exhaustive sweep of 0..255 checked against a reference divide/modulo model.
